// File: rtl/kpn_pkg.sv
// kpn_pkg
// Shared definitions for the Kahn Process Network nodes: FSM state
// encoding, the default token width and the width of the produced-token
// counter.
package kpn_pkg;

   // Default token width; matches the data width of the queue modules.
   localparam int BITS_NUMBER_DEF = 16;

   // Width of the running produced-token counter.
   localparam int TOKEN_COUNT_W = 16;

   // Node FSM states. The encoding is fixed so that other KPN blocks and
   // debug views agree on the values.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WAIT  = 2'd2,
      ST_WRITE = 2'd3
   } kpn_state_e;

endpackage : kpn_pkg

// File: rtl/kpn_adder_process.sv
// kpn_adder_process
// KPN "add" node. It pops one token from each of two input queues, adds
// them modulo 2^BITS_NUMBER and pushes the sum into an output queue. It
// blocks on empty inputs and on a full output queue, and counts the
// tokens it has written.
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous, active-high reset
//   empty_1/2    input queue has no token
//   rd_1/2       read strobes to the input queues (both or neither)
//   input_1/2    queue data, valid the cycle after the read edge
//   full_out     output queue cannot accept a token
//   wr           write strobe to the output queue
//   output_1     registered sum token
//   token_count  tokens written since reset, wraps
module kpn_adder_process
   import kpn_pkg::*;
#(
   parameter int BITS_NUMBER = BITS_NUMBER_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     empty_1,
   input  logic                     empty_2,
   output logic                     rd_1,
   output logic                     rd_2,
   input  logic [BITS_NUMBER-1:0]   input_1,
   input  logic [BITS_NUMBER-1:0]   input_2,
   input  logic                     full_out,
   output logic                     wr,
   output logic [BITS_NUMBER-1:0]   output_1,
   output logic [TOKEN_COUNT_W-1:0] token_count
);

   kpn_state_e                 state_q;
   kpn_state_e                 state_d;
   logic [BITS_NUMBER-1:0]     sum_q;
   logic [BITS_NUMBER-1:0]     sum_d;
   logic [TOKEN_COUNT_W-1:0]   count_q;
   logic [TOKEN_COUNT_W-1:0]   count_d;
   logic                       both_ready_s;
   logic                       xfer_s;

   // Both queues must hold a token; a single-sided read is never issued.
   assign both_ready_s = ~empty_1 & ~empty_2;
   // A token leaves the node on the edge that ends a non-blocked WRITE.
   assign xfer_s       = (state_q == ST_WRITE) & ~full_out;

   // State register; reset aborts any in-flight read and returns to IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; empties are only looked at in IDLE and at the
   // WRITE hand-off, so a started read is always completed.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (both_ready_s) begin
               state_d = ST_READ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            if (full_out) begin
               state_d = ST_WRITE;
            end else if (both_ready_s) begin
               state_d = ST_READ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Moore read strobes; the write strobe is gated by back-pressure.
   always_comb begin
      rd_1 = 1'b0;
      rd_2 = 1'b0;
      wr   = 1'b0;
      case (state_q)
         ST_READ: begin
            rd_1 = 1'b1;
            rd_2 = 1'b1;
         end
         ST_WRITE: begin
            wr = ~full_out;
         end
         default: begin
            rd_1 = 1'b0;
            rd_2 = 1'b0;
            wr   = 1'b0;
         end
      endcase
   end

   // Datapath next values: the sum is captured only at the end of WAIT
   // (carry dropped by the width), the counter steps on each transfer.
   always_comb begin
      sum_d   = sum_q;
      count_d = count_q;
      if (state_q == ST_WAIT) begin
         sum_d = input_1 + input_2;
      end else begin
         sum_d = sum_q;
      end
      if (xfer_s) begin
         count_d = count_q + TOKEN_COUNT_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Datapath registers for the sum token and the produced-token count.
   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q   <= {BITS_NUMBER{1'b0}};
         count_q <= {TOKEN_COUNT_W{1'b0}};
      end else begin
         sum_q   <= sum_d;
         count_q <= count_d;
      end
   end

   assign output_1    = sum_q;
   assign token_count = count_q;

endmodule : kpn_adder_process

// File: doc/kpn_adder_process.md
# kpn_adder_process

Kahn Process Network "add" node that sits directly downstream of two `queue_module` FIFOs and upstream of an output FIFO. It pops one token from each input queue, adds them modulo 2^BITS_NUMBER, and pushes the sum into the output queue, blocking on empty inputs or a full output as KPN semantics require. It also keeps a running count of tokens produced.

## Interface
- `BITS_NUMBER`, 16, token width in bits; matches the queue data width.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `empty_1`  in  1  input queue 1 has no token.
- `empty_2`  in  1  input queue 2 has no token.
- `rd_1`  out  1  read strobe to queue 1.
- `rd_2`  out  1  read strobe to queue 2.
- `input_1`  in  BITS_NUMBER  data from queue 1; valid the cycle after the `rd_1` edge.
- `input_2`  in  BITS_NUMBER  data from queue 2; valid the cycle after the `rd_2` edge.
- `full_out`  in  1  output queue cannot accept a token.
- `wr`  out  1  write strobe to the output queue.
- `output_1`  out  BITS_NUMBER  sum token presented to the output queue.
- `token_count`  out  16  number of tokens written since reset; wraps.

## Operation
- FSM states: IDLE, READ, WAIT, WRITE.
- **IDLE**
  - Go to READ when `~empty_1 & ~empty_2`; otherwise stay.
  - Never read only one queue.
- **READ**
  - Assert `rd_1` and `rd_2` together, for exactly one cycle.
  - Always go to WAIT.
- **WAIT**
  - Queues drive `input_1` and `input_2` this cycle.
  - At the end of the cycle, register `sum = input_1 + input_2` (carry discarded, wraps modulo 2^BITS_NUMBER) into `output_1`.
  - Go to WRITE.
- **WRITE**
  - `output_1` holds the sum.
  - `wr = ~full_out` (combinational from state and `full_out`).
  - While `full_out` is high, stay in WRITE with `wr` = 0 and `output_1` stable.
  - When `full_out` is low: the token transfers at that edge and `token_count` increments (wraps 0xFFFF→0). Next state is READ if both inputs are non-empty, else IDLE.
- `rd_1`/`rd_2` are Moore outputs, high only in READ.
- `wr` is high only in WRITE.
- Empty flags are ignored in WAIT and WRITE; a token read is always completed.
- `output_1` changes only at the end of WAIT or on reset.

## Timing
- Reset (synchronous, has priority over everything):
  - state = IDLE; `rd_1` = `rd_2` = 0; `wr` = 0; `output_1` = 0; `token_count` = 0.
- Reset during READ, WAIT or WRITE aborts the operation. Popped tokens are discarded, no write occurs, and the next cycle is IDLE.
- Latency, from the edge that sees both queues non-empty in IDLE (E0):
  - READ during cycle E0–E1.
  - WAIT during E1–E2; operands sampled at E2.
  - WRITE from E2; token handed off at E3 if `full_out` = 0.
- Throughput: one token per 3 cycles when back-to-back (WRITE→READ→WAIT→WRITE).
- Back-pressure: each cycle of `full_out` = 1 in WRITE adds one cycle; the data is held.
- If `full_out` and empties change in the same cycle as the WRITE transfer, the next state is decided on that edge's sampled values.

## Structure
- Shared package `kpn_pkg`:
  - state encoding constants (IDLE = 2'd0, READ = 2'd1, WAIT = 2'd2, WRITE = 2'd3);
  - default `BITS_NUMBER` = 16;
  - `token_count` width = 16.
- No sub-module; FSM, adder and counter live in one module.
- A bench wrapper instantiates two `queue_module` inputs plus one output FIFO.

## Test plan
- Reset, then both queues empty for 10 cycles → `rd_1`/`rd_2`/`wr` stay 0; `output_1` = 0; `token_count` = 0.
- Queue 1 holds 0x0003, queue 2 holds 0x0004, `full_out` = 0 → `rd_1`/`rd_2` high one cycle; `wr` high at E2 with `output_1` = 0x0007; `token_count` = 1 after E3.
- Inputs 0xFFFF + 0x0002 → `output_1` = 0x0001 (wrap, no flag).
- Four token pairs queued, no back-pressure → exactly 4 writes, spaced 3 cycles apart; `token_count` = 4.
- `full_out` high for 5 cycles during WRITE → `wr` = 0 for those cycles, `output_1` constant, then a single write; total latency 8 cycles.
- Only queue 1 non-empty → no read on either queue. `reset` asserted in WAIT → next cycle is IDLE, no `wr`, `token_count` unchanged at 0.
